// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing derived from clock/baud, and receive FSM state encodings.
package uart_pkg;

    // Clock cycles per bit on the line.
    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Cycles from a symbol edge to its midpoint.
    function automatic int unsigned sample_time(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

    // One-hot receive states.
    typedef enum logic [4:0] {
        RX_IDLE      = 5'b00001,
        RX_START     = 5'b00010,
        RX_DATA      = 5'b00100,
        RX_STOP      = 5'b01000,
        RX_WAIT_HIGH = 5'b10000
    } rx_state_t;

endpackage

// File: rtl/uart_receiver_synchronizer.sv
// Two-flop synchronizer for asynchronous inputs; flops reset to all-ones (idle-high lines).
module synchronizer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Double-register the input into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, false-start rejection, framing error detection,
// and a one-entry valid/ready holding register with overrun reporting.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int unsigned SYMBOL_EDGE_TIME    = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned SAMPLE_TIME         = sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CLOCK_COUNTER_WIDTH-1:0] SAMPLE_LAST = CLOCK_COUNTER_WIDTH'(SAMPLE_TIME - 1);
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] SYMBOL_LAST = CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] COUNT_ONE   = CLOCK_COUNTER_WIDTH'(1);

    logic                           rx;
    rx_state_t                      state, state_next;
    logic [CLOCK_COUNTER_WIDTH-1:0] count, count_next;
    logic [2:0]                     bit_idx, bit_idx_next;
    logic [7:0]                     shift;
    logic                           sample_bit;
    logic                           commit;
    logic                           frame_err;

    synchronizer #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (serial_in),
        .q     (rx)
    );

    // State, counters and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RX_IDLE;
            count   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            bit_idx <= bit_idx_next;
            if (sample_bit) shift[bit_idx] <= rx;
        end
    end

    // Next-state logic and sampling strobes.
    always_comb begin
        state_next   = state;
        count_next   = count + COUNT_ONE;
        bit_idx_next = bit_idx;
        sample_bit   = 1'b0;
        commit       = 1'b0;
        frame_err    = 1'b0;
        unique case (state)
            RX_IDLE: begin
                count_next = '0;
                // The start-edge cycle counts as cycle 0, so START begins at 1.
                if (!rx) begin
                    state_next = RX_START;
                    count_next = COUNT_ONE;
                end
            end
            RX_START: begin
                if (count == SAMPLE_LAST) begin
                    count_next   = '0;
                    bit_idx_next = '0;
                    state_next   = rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (count == SYMBOL_LAST) begin
                    count_next   = '0;
                    sample_bit   = 1'b1;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (count == SYMBOL_LAST) begin
                    count_next = '0;
                    if (rx) begin
                        commit     = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                count_next = '0;
                if (rx) state_next = RX_IDLE;
            end
            default: begin
                count_next = '0;
                state_next = RX_IDLE;
            end
        endcase
    end

    // Holding register, handshake and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            framing_error  <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            framing_error <= frame_err;
            overrun       <= 1'b0;
            if (commit) begin
                if (!data_out_valid || data_out_ready) begin
                    data_out       <= shift;
                    data_out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized checks of uart_receiver at 10 cycles per bit.
module tb_uart_receiver;

    localparam int unsigned CF  = 1_000_000;
    localparam int unsigned BR  = 100_000;
    localparam int unsigned SET = CF / BR;
    // Drive-to-valid latency: 2 sync flops + stop sample at (SET/2-1)+9*SET + 1 register stage.
    localparam int unsigned LATENCY = 2 + (SET / 2 - 1) + 9 * SET + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    always #5 clk = ~clk;

    uart_receiver #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk            (clk),
        .reset          (reset),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .framing_error  (framing_error),
        .overrun        (overrun)
    );

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: accepted bytes, pulse counts, valid occupancy and rise time.
    logic [7:0]  got[$];
    int          fe_cnt   = 0;
    int          ov_cnt   = 0;
    int          v_cnt    = 0;
    int unsigned rise_cyc = 0;
    logic        prev_v   = 1'b0;

    always @(negedge clk) begin
        if (data_out_valid && data_out_ready) got.push_back(data_out);
        if (framing_error) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (data_out_valid) v_cnt <= v_cnt + 1;
        if (data_out_valid && !prev_v) rise_cyc <= cyc;
        prev_v <= data_out_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_in = bits[i];
            tick(SET);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_got(input string tag, input logic [7:0] b);
        logic [7:0] v;
        check({tag, "_present"}, 32'(got.size() > 0), 32'd1);
        if (got.size() > 0) begin
            v = got.pop_front();
            check(tag, 32'(v), 32'(b));
        end
    endtask

    initial begin
        int unsigned s;
        int          v0, fe0, ov0;
        logic [7:0]  r;
        logic [7:0]  exp_q[$];
        int          gap;

        reset = 1'b1;
        serial_in = 1'b1;
        data_out_ready = 1'b1;
        tick(3);
        check("reset_data", 32'(data_out), 32'h00);
        check("reset_valid", 32'(data_out_valid), 32'd0);
        check("reset_fe", 32'(framing_error), 32'd0);
        check("reset_ov", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick(5);

        // 1: clean frame, ready held high
        s = cyc; v0 = v_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'hA5, 1'b1);
        tick(5);
        check("t1_latency", rise_cyc - s, LATENCY);
        check("t1_valid_cycles", 32'(v_cnt - v0), 32'd1);
        expect_got("t1_byte", 8'hA5);
        check("t1_fe", 32'(fe_cnt - fe0), 32'd0);
        check("t1_ov", 32'(ov_cnt - ov0), 32'd0);

        // 2: short glitch rejected, then a normal frame
        v0 = v_cnt;
        serial_in = 1'b0;
        tick(3);
        serial_in = 1'b1;
        tick(20);
        check("t2_no_valid", 32'(v_cnt - v0), 32'd0);
        check("t2_no_byte", 32'(got.size()), 32'd0);
        s = cyc;
        send_frame(8'h3C, 1'b1);
        tick(5);
        check("t2_latency", rise_cyc - s, LATENCY);
        expect_got("t2_byte", 8'h3C);

        // 3: bad stop bit with line held low
        fe0 = fe_cnt; v0 = v_cnt;
        send_frame(8'h55, 1'b0);
        tick(20);
        serial_in = 1'b1;
        tick(10);
        check("t3_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
        check("t3_no_valid", 32'(v_cnt - v0), 32'd0);
        send_frame(8'h0F, 1'b1);
        tick(5);
        expect_got("t3_byte", 8'h0F);

        // 4: overrun while holding register is full
        data_out_ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(5);
        check("t4_ov_pulses", 32'(ov_cnt - ov0), 32'd1);
        check("t4_data_kept", 32'(data_out), 32'h11);
        check("t4_valid", 32'(data_out_valid), 32'd1);
        check("t4_none_taken", 32'(got.size()), 32'd0);
        data_out_ready = 1'b1;
        tick(1);
        data_out_ready = 1'b0;
        check("t4_valid_drop", 32'(data_out_valid), 32'd0);
        expect_got("t4_byte", 8'h11);

        // 5: accept coincides with the next commit
        send_frame(8'h11, 1'b1);
        tick(3);
        check("t5_hold_valid", 32'(data_out_valid), 32'd1);
        check("t5_hold_data", 32'(data_out), 32'h11);
        ov0 = ov_cnt;
        fork
            send_frame(8'h22, 1'b1);
            begin
                tick(LATENCY - 1);
                data_out_ready = 1'b1;
                tick(1);
                data_out_ready = 1'b0;
            end
        join
        tick(3);
        check("t5_no_ov", 32'(ov_cnt - ov0), 32'd0);
        check("t5_data", 32'(data_out), 32'h22);
        check("t5_valid", 32'(data_out_valid), 32'd1);
        expect_got("t5_first", 8'h11);
        data_out_ready = 1'b1;
        tick(1);
        expect_got("t5_second", 8'h22);
        check("t5_valid_drop", 32'(data_out_valid), 32'd0);

        // 6: async reset during data bit 4 with a byte held
        data_out_ready = 1'b0;
        r = 8'($urandom_range(1, 255));
        send_frame(r, 1'b1);
        tick(3);
        check("t6_pre_valid", 32'(data_out_valid), 32'd1);
        check("t6_pre_data", 32'(data_out), 32'(r));
        fork
            send_frame(8'($urandom), 1'b1);
            begin
                tick(55);
                #2 reset = 1'b1;
                #1;
                check("t6_async_valid", 32'(data_out_valid), 32'd0);
                check("t6_async_data", 32'(data_out), 32'h00);
                check("t6_async_fe", 32'(framing_error), 32'd0);
                check("t6_async_ov", 32'(overrun), 32'd0);
            end
        join
        reset = 1'b0;
        data_out_ready = 1'b1;
        tick(5);
        check("t6_post_valid", 32'(data_out_valid), 32'd0);
        check("t6_no_byte", 32'(got.size()), 32'd0);
        send_frame(8'h80, 1'b1);
        tick(5);
        expect_got("t6_byte", 8'h80);

        // Random bytes with random inter-frame gaps (including zero)
        for (int i = 0; i < 10; i++) begin
            r = 8'($urandom);
            exp_q.push_back(r);
            send_frame(r, 1'b1);
            gap = int'($urandom_range(0, 12));
            if (i % 3 == 0) gap = 0;
            if (gap > 0) tick(gap);
        end
        tick(10);
        check("rnd_count", 32'(got.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            expect_got("rnd_byte", r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel receive half of the on-board UART (8N1, LSB first, idle-high line); pairs with the existing transmitter.
- Oversamples serial_in with the system clock, samples each bit at mid-symbol, rejects false starts and flags framing errors.
- Delivers bytes through a one-entry valid/ready holding register to the CPU-side MMIO/FIFO logic, with an overrun flag.

Parameters:
- CLOCK_FREQ, 125_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- Derived locals (not overridable):
  - SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE, cycles per bit.
  - SAMPLE_TIME = SYMBOL_EDGE_TIME/2.
  - Counter width = $clog2(SYMBOL_EDGE_TIME).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- serial_in  input  1  asynchronous UART line, idle high.
- data_out  output  8  received byte, valid while data_out_valid=1.
- data_out_valid  output  1  holding register full.
- data_out_ready  input  1  consumer accepts byte when valid&ready.
- framing_error  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: completed byte dropped because holding register still full.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE; synchronizer flops=1; counters=0.
  - data_out=8'h00, data_out_valid=0, framing_error=0, overrun=0.
  - Reset mid-frame abandons the frame; the held byte is discarded.
- Input path: 2-flop synchronizer on serial_in; "rx" below is the second flop output. All timing is counted from the first cycle rx=0 in IDLE (cycle 0).
- FSM states (one-hot): IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx=0 -> START, clock counter cleared.
  - START: at counter=SAMPLE_TIME-1, sample rx.
    - rx=1 -> glitch; return to IDLE, no output.
    - rx=0 -> DATA; counter=0, bit index=0.
  - DATA: every SYMBOL_EDGE_TIME cycles (counter=SYMBOL_EDGE_TIME-1), sample rx into shift[bit index]. LSB first.
    - Bits are sampled at cycle SAMPLE_TIME-1+k*SYMBOL_EDGE_TIME for k=1..8.
    - After bit 7 -> STOP.
  - STOP: sample at k=9.
    - rx=1 -> commit byte; go to IDLE.
    - rx=0 -> framing_error=1 for that cycle; byte discarded; go to WAIT_HIGH.
  - WAIT_HIGH: remain until rx=1, then IDLE. A held-low line (break) produces exactly one framing_error pulse.
- Commit and handshake:
  - A commit sets data_out and data_out_valid=1 on the cycle after the stop sample.
  - valid&ready in a cycle clears data_out_valid on the next edge.
  - data_out is stable while valid=1 and not yet accepted.
- Overrun: a commit while data_out_valid=1 and data_out_ready=0 drops the new byte, keeps the old byte, and pulses overrun for one cycle (the cycle after the stop sample).
- Simultaneous events: a commit in the same cycle as valid&ready loads the new byte, keeps valid=1, and raises no overrun.
- Back-to-back frames: the receiver returns to IDLE at mid-stop-bit, so the next start edge arriving half a bit later is detected. Zero inter-frame gap is supported.
- Arithmetic: counters are unsigned, compared with CLOCK_COUNTER_WIDTH-bit constants. bit index is 3 bits and never wraps inside a frame.

Decomposition:
- Shared package/header uart_pkg holds:
  - Derived timing constants SYMBOL_EDGE_TIME and SAMPLE_TIME, so transmitter and receiver share a single definition.
  - One-hot receive state encodings.
- One sub-module: synchronizer (parameterised width, reset value 1), reusable for other async inputs.
- FSM and holding register stay in uart_receiver.

Test Plan:
All tests use CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, giving 10 cycles/bit with sampling at count 4.
1. Frame 0xA5 with correct 8N1 timing, ready held 1 -> data_out=0xA5, valid high exactly 1 cycle, framing_error=0, overrun=0.
2. serial_in low for 3 cycles, then high -> no valid, FSM back to IDLE. A following frame 0x3C is received as 0x3C.
3. Frame 0x55 with stop bit 0, line held low 30 cycles -> single framing_error pulse, no valid. After the line goes high, frame 0x0F yields 0x0F.
4. ready=0; frames 0x11 then 0x22 -> data_out stays 0x11 with valid=1, and one overrun pulse at the 0x22 commit. Raising ready then consumes 0x11, and valid drops.
5. Valid holding 0x11; ready asserted exactly in the 0x22 commit cycle -> no overrun, data_out=0x22, valid stays 1.
6. Assert reset during data bit 4 of a frame -> valid=0 and outputs cleared immediately (asynchronously). After release, frame 0x80 is received correctly.
